mem_exec_pipe_param: RTL and testbench



---
 rtl/mem_pipe_pkg.sv | 48 ++++
 rtl/mem_pipe_skid_fifo.sv | 70 +++++++
 rtl/mem_exec_pipe_param.sv | 177 +++++++++++++++++
 tb/tb_mem_exec_pipe_param.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mem_pipe_pkg
// Shared types for the memory-lane execution pipe.
//   memSize_t    : access size encoding (byte/half/word/dword)
//   memReqPkt    : LSU request packet at the default lane widths
//   misalignChk  : natural-alignment check on the low address bits
// -----------------------------------------------------------------------------
package mem_pipe_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HALF  = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } memSize_t;

    localparam int PKT_DATA_W = 64;
    localparam int PKT_ADDR_W = 64;
    localparam int PKT_AL_W   = 7;
    localparam int PKT_TAG_W  = 7;
    localparam int PKT_LSQ_W  = 5;

    // Request packet as seen by the LSU in the default lane configuration.
    typedef struct packed {
        logic [PKT_ADDR_W-1:0] addr;
        logic                  isStore;
        memSize_t              size;
        logic [PKT_DATA_W-1:0] stData;
        logic [PKT_AL_W-1:0]   alId;
        logic [PKT_TAG_W-1:0]  phyDest;
        logic [PKT_LSQ_W-1:0]  lsqId;
        logic                  misalign;
    } memReqPkt;

    // Only the low three address bits matter for sizes up to a dword.
    function automatic logic misalignChk(input logic [2:0] addrLo, input memSize_t size);
        logic bad;
        bad = 1'b0;
        case (size)
            HALF:    bad = addrLo[0];
            WORD:    bad = |addrLo[1:0];
            DWORD:   bad = |addrLo;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_pipe_skid_fifo.sv
// -----------------------------------------------------------------------------
// mem_pipe_skid_fifo
// Circular skid buffer between the address-generation stages and the LSU.
// No empty bypass: a pushed entry is visible at the head one cycle later.
//   clk, reset    : clock, asynchronous active-high reset
//   flush         : clears pointers and count at the next edge
//   push/pushData : write an entry (caller guarantees fifoRoom)
//   pop           : retire the head entry (caller guarantees notEmpty)
//   headData      : oldest entry
//   notEmpty      : count != 0
//   fifoRoom      : count < DEPTH, from the registered count only
// -----------------------------------------------------------------------------
module mem_pipe_skid_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             notEmpty,
    output logic             fifoRoom
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= ptrInc(wrPtr);
            if (pop)  rdPtr <= ptrInc(rdPtr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; entries are meaningless until counted.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= pushData;
    end

    assign headData = mem[rdPtr];
    assign notEmpty = (count != '0);
    assign fifoRoom = (count < CNT_W'(DEPTH));

endmodule

// File: rtl/mem_exec_pipe_param.sv
// -----------------------------------------------------------------------------
// mem_exec_pipe_param
// Load/store execution pipe: AGEN_STAGES address-generation registers with
// bubble collapse, followed by a SKID_DEPTH-entry skid buffer toward the LSU.
// Optional feature macro: MEM_PIPE_MISALIGN_CHECK_EN (alignment flag carried
// with each op; when undefined memMisalign_o is tied low and no bit is stored).
//   clk, reset          : clock, asynchronous active-high reset
//   flush_i             : drop everything in flight at the next edge
//   issValid_i/issReady_o : issue handshake; issReady_o never depends on memReady_i
//   iss*_i              : op kind, size, base, 12-bit signed imm, store data, tags
//   memValid_o/memReady_i : LSU handshake
//   mem*_o              : head-of-buffer op (address, kind, size, data, tags)
//   memMisalign_o       : alignment flag for the head op
//   stallCnt_o          : saturating count of LSU-stalled valid cycles
// -----------------------------------------------------------------------------
module mem_exec_pipe_param
    import mem_pipe_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 64,
    parameter int AL_W        = 7,
    parameter int TAG_W       = 7,
    parameter int LSQ_W       = 5,
    parameter int AGEN_STAGES = 1,
    parameter int SKID_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              issValid_i,
    output logic              issReady_o,
    input  logic              issIsStore_i,
    input  logic [1:0]        issSize_i,
    input  logic [DATA_W-1:0] issBase_i,
    input  logic [11:0]       issImm_i,
    input  logic [DATA_W-1:0] issStData_i,
    input  logic [AL_W-1:0]   issAlId_i,
    input  logic [TAG_W-1:0]  issPhyDest_i,
    input  logic [LSQ_W-1:0]  issLsqId_i,
    output logic              memValid_o,
    input  logic              memReady_i,
    output logic [ADDR_W-1:0] memAddr_o,
    output logic              memIsStore_o,
    output logic [1:0]        memSize_o,
    output logic [DATA_W-1:0] memStData_o,
    output logic [AL_W-1:0]   memAlId_o,
    output logic [TAG_W-1:0]  memPhyDest_o,
    output logic [LSQ_W-1:0]  memLsqId_o,
    output logic              memMisalign_o,
    output logic [15:0]       stallCnt_o
);

    localparam int LAST = AGEN_STAGES - 1;

    // Width-parameterised stage payload (memReqPkt is fixed at default widths).
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              isStore;
        memSize_t          size;
        logic [DATA_W-1:0] stData;
        logic [AL_W-1:0]   alId;
        logic [TAG_W-1:0]  phyDest;
        logic [LSQ_W-1:0]  lsqId;
`ifdef MEM_PIPE_MISALIGN_CHECK_EN
        logic              misalign;
`endif
    } stagePkt_t;

    logic [AGEN_STAGES-1:0] stgVld;
    logic [AGEN_STAGES-1:0] stgLoad;
    stagePkt_t              stgPkt [AGEN_STAGES];
    stagePkt_t              stgIn  [AGEN_STAGES];
    logic [ADDR_W-1:0]      agenAddr;
    logic                   chainFull;
    logic                   fifoRoom;
    logic                   fifoNotEmpty;
    logic                   fifoPush;
    logic                   fifoPop;
    stagePkt_t              head;

    // Carry out of ADDR_W is dropped, so the address wraps.
    assign agenAddr = issBase_i[ADDR_W-1:0] + {{(ADDR_W-12){issImm_i[11]}}, issImm_i};

    always_comb begin
        stgIn[0]         = '0;
        stgIn[0].addr    = agenAddr;
        stgIn[0].isStore = issIsStore_i;
        stgIn[0].size    = memSize_t'(issSize_i);
        stgIn[0].stData  = issStData_i;
        stgIn[0].alId    = issAlId_i;
        stgIn[0].phyDest = issPhyDest_i;
        stgIn[0].lsqId   = issLsqId_i;
        for (int k = 1; k < AGEN_STAGES; k++) begin
            stgIn[k] = stgPkt[k-1];
        end
`ifdef MEM_PIPE_MISALIGN_CHECK_EN
        stgIn[LAST].misalign = misalignChk(stgIn[LAST].addr[2:0], stgIn[LAST].size);
`endif
    end

    // A stage may load if any stage from it to the last is empty, or the
    // buffer has room; this is the unrolled bubble-collapse chain and reads
    // only registered state.
    always_comb begin
        chainFull = 1'b1;
        stgLoad   = '0;
        for (int k = LAST; k >= 0; k--) begin
            chainFull  = chainFull & stgVld[k];
            stgLoad[k] = !chainFull | fifoRoom;
        end
    end

    assign issReady_o = stgLoad[0];
    assign fifoPush   = stgVld[LAST] & fifoRoom;
    assign memValid_o = fifoNotEmpty & !flush_i;
    assign fifoPop    = memValid_o & memReady_i;

    // ---- AGEN stages: control ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stgVld <= '0;
        end else if (flush_i) begin
            stgVld <= '0;
        end else begin
            if (stgLoad[0]) stgVld[0] <= issValid_i;
            for (int k = 1; k < AGEN_STAGES; k++) begin
                if (stgLoad[k]) stgVld[k] <= stgVld[k-1];
            end
        end
    end

    // ---- AGEN stages: payload ----
    always_ff @(posedge clk) begin
        for (int k = 0; k < AGEN_STAGES; k++) begin
            if (stgLoad[k]) stgPkt[k] <= stgIn[k];
        end
    end

    // ---- skid buffer ----
    mem_pipe_skid_fifo #(
        .WIDTH ($bits(stagePkt_t)),
        .DEPTH (SKID_DEPTH)
    ) uSkid (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush_i),
        .push     (fifoPush),
        .pushData (stgPkt[LAST]),
        .pop      (fifoPop),
        .headData (head),
        .notEmpty (fifoNotEmpty),
        .fifoRoom (fifoRoom)
    );

    // ---- stall counter ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCnt_o <= '0;
        end else if (memValid_o && !memReady_i && (stallCnt_o != 16'hFFFF)) begin
            stallCnt_o <= stallCnt_o + 16'd1;
        end
    end

    assign memAddr_o    = head.addr;
    assign memIsStore_o = head.isStore;
    assign memSize_o    = head.size;
    assign memStData_o  = head.stData;
    assign memAlId_o    = head.alId;
    assign memPhyDest_o = head.phyDest;
    assign memLsqId_o   = head.lsqId;
`ifdef MEM_PIPE_MISALIGN_CHECK_EN
    assign memMisalign_o = head.misalign;
`else
    assign memMisalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_exec_pipe_param.sv
// -----------------------------------------------------------------------------
// tb_mem_exec_pipe_param
// Bench for mem_exec_pipe_param. dutA uses default parameters; dutB uses
// ADDR_W=32, AGEN_STAGES=2, SKID_DEPTH=4 and shares all inputs.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Latency is counted in cycles from the handshake cycle.
// -----------------------------------------------------------------------------
module tb_mem_exec_pipe_param;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        issValid;
    logic        issIsStore;
    logic [1:0]  issSize;
    logic [63:0] issBase;
    logic [11:0] issImm;
    logic [63:0] issStData;
    logic [6:0]  issAlId;
    logic [6:0]  issPhyDest;
    logic [4:0]  issLsqId;
    logic        memReady;

    logic        aIssReady, aMemValid, aMemIsStore, aMemMisalign;
    logic [63:0] aMemAddr, aMemStData;
    logic [1:0]  aMemSize;
    logic [6:0]  aMemAlId, aMemPhyDest;
    logic [4:0]  aMemLsqId;
    logic [15:0] aStallCnt;

    logic        bIssReady, bMemValid, bMemIsStore, bMemMisalign;
    logic [31:0] bMemAddr;
    logic [63:0] bMemStData;
    logic [1:0]  bMemSize;
    logic [6:0]  bMemAlId, bMemPhyDest;
    logic [4:0]  bMemLsqId;
    logic [15:0] bStallCnt;

    mem_exec_pipe_param dutA (
        .clk(clk), .reset(reset), .flush_i(flush),
        .issValid_i(issValid), .issReady_o(aIssReady),
        .issIsStore_i(issIsStore), .issSize_i(issSize), .issBase_i(issBase),
        .issImm_i(issImm), .issStData_i(issStData), .issAlId_i(issAlId),
        .issPhyDest_i(issPhyDest), .issLsqId_i(issLsqId),
        .memValid_o(aMemValid), .memReady_i(memReady), .memAddr_o(aMemAddr),
        .memIsStore_o(aMemIsStore), .memSize_o(aMemSize), .memStData_o(aMemStData),
        .memAlId_o(aMemAlId), .memPhyDest_o(aMemPhyDest), .memLsqId_o(aMemLsqId),
        .memMisalign_o(aMemMisalign), .stallCnt_o(aStallCnt)
    );

    mem_exec_pipe_param #(.ADDR_W(32), .AGEN_STAGES(2), .SKID_DEPTH(4)) dutB (
        .clk(clk), .reset(reset), .flush_i(flush),
        .issValid_i(issValid), .issReady_o(bIssReady),
        .issIsStore_i(issIsStore), .issSize_i(issSize), .issBase_i(issBase),
        .issImm_i(issImm), .issStData_i(issStData), .issAlId_i(issAlId),
        .issPhyDest_i(issPhyDest), .issLsqId_i(issLsqId),
        .memValid_o(bMemValid), .memReady_i(memReady), .memAddr_o(bMemAddr),
        .memIsStore_o(bMemIsStore), .memSize_o(bMemSize), .memStData_o(bMemStData),
        .memAlId_o(bMemAlId), .memPhyDest_o(bMemPhyDest), .memLsqId_o(bMemLsqId),
        .memMisalign_o(bMemMisalign), .stallCnt_o(bStallCnt)
    );

    typedef struct {
        logic        isStore;
        logic [1:0]  size;
        logic [63:0] base;
        logic [11:0] imm;
        logic [63:0] stData;
        logic [6:0]  alId;
        logic [6:0]  phyDest;
        logic [4:0]  lsqId;
        logic [63:0] expAddr;
        logic        expMis;   // flag value when the alignment check is built in
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        logic        isStore;
        logic [1:0]  size;
        logic [63:0] stData;
        logic [6:0]  alId;
        logic [6:0]  phyDest;
        logic [4:0]  lsqId;
        logic        mis;
    } exp_t;

    exp_t sbQ[$];
    exp_t monE;
    int   tests = 0;
    int   fails = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic refMis(input logic [2:0] a, input logic [1:0] sz);
        case (sz)
            2'd1:    return a[0];
            2'd2:    return a[1:0] != 2'b00;
            2'd3:    return a != 3'b000;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic misOf(input vec_t v);
`ifdef MEM_PIPE_MISALIGN_CHECK_EN
        return v.expMis;
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t toExp(input vec_t v);
        exp_t e;
        e.addr = v.expAddr; e.isStore = v.isStore; e.size = v.size;
        e.stData = v.stData; e.alId = v.alId; e.phyDest = v.phyDest;
        e.lsqId = v.lsqId; e.mis = misOf(v);
        return e;
    endfunction

    function automatic vec_t mkVec(input logic st, input logic [1:0] sz, input logic [63:0] b,
                                   input logic [11:0] im, input logic [63:0] ea, input logic em,
                                   input int id);
        vec_t v;
        v.isStore = st; v.size = sz; v.base = b; v.imm = im;
        v.stData = 64'hD000_0000_0000_0000 | 64'(id * 3 + 1);
        v.alId = 7'(id); v.phyDest = 7'(id + 40); v.lsqId = 5'(id);
        v.expAddr = ea; v.expMis = em;
        return v;
    endfunction

    function automatic vec_t randVec();
        vec_t v;
        v.isStore = 1'($urandom_range(0, 1));
        v.size    = 2'($urandom_range(0, 3));
        v.base    = {$urandom, $urandom};
        v.imm     = 12'($urandom);
        v.stData  = {$urandom, $urandom};
        v.alId    = 7'($urandom);
        v.phyDest = 7'($urandom);
        v.lsqId   = 5'($urandom);
        v.expAddr = v.base + {{52{v.imm[11]}}, v.imm};
        v.expMis  = refMis(v.expAddr[2:0], v.size);
        return v;
    endfunction

    task automatic setIss(input vec_t v);
        issIsStore = v.isStore; issSize = v.size; issBase = v.base; issImm = v.imm;
        issStData = v.stData; issAlId = v.alId; issPhyDest = v.phyDest; issLsqId = v.lsqId;
    endtask

    // Offer one op for up to maxCyc cycles; records the expectation on accept.
    task automatic offer(input vec_t v, input int maxCyc, output bit acc);
        acc = 1'b0;
        setIss(v);
        issValid = 1'b1;
        for (int i = 0; i < maxCyc && !acc; i++) begin
            @(negedge clk);
            if (aIssReady && !flush) begin
                acc = 1'b1;
                sbQ.push_back(toExp(v));
            end
            @(posedge clk); #1;
        end
        issValid = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int maxCyc);
        for (int i = 0; i < maxCyc && sbQ.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check(name, 64'(sbQ.size()), 64'd0);
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // Output scoreboard for dutA.
    always @(negedge clk) begin
        if (!reset) begin
            if (aMemValid && memReady) begin
                tests++;
                if (sbQ.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out: got addr 0x%0h, expected no output", aMemAddr);
                end else begin
                    monE = sbQ.pop_front();
                    if ({aMemAddr, aMemIsStore, aMemSize, aMemStData, aMemAlId, aMemPhyDest,
                         aMemLsqId, aMemMisalign} !==
                        {monE.addr, monE.isStore, monE.size, monE.stData, monE.alId,
                         monE.phyDest, monE.lsqId, monE.mis}) begin
                        fails++;
                        $display("FAIL out_pkt: got addr=0x%0h st=%0d sz=%0d al=%0d mis=%0d, expected addr=0x%0h st=%0d sz=%0d al=%0d mis=%0d",
                                 aMemAddr, aMemIsStore, aMemSize, aMemAlId, aMemMisalign,
                                 monE.addr, monE.isStore, monE.size, monE.alId, monE.mis);
                    end
                end
            end
            if (flush) sbQ.delete();
        end
    end

    vec_t tbl[8];
    vec_t v;
    bit   acc, a1, a2, a3, a4;

    initial begin
        tbl[0] = mkVec(1'b0, 2'd3, 64'h1000,                 12'hFF8, 64'hFF8,                 1'b0, 0);
        tbl[1] = mkVec(1'b1, 2'd2, 64'h2000,                 12'h7FF, 64'h27FF,                1'b1, 1);
        tbl[2] = mkVec(1'b0, 2'd0, 64'h0,                    12'hFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2);
        tbl[3] = mkVec(1'b1, 2'd3, 64'hFFFF_FFFF_FFFF_FFF0, 12'h010, 64'h0,                   1'b0, 3);
        tbl[4] = mkVec(1'b0, 2'd1, 64'h1234_5678_9ABC_DEF0, 12'h800, 64'h1234_5678_9ABC_D6F0, 1'b0, 4);
        tbl[5] = mkVec(1'b0, 2'd2, 64'h1000,                 12'h002, 64'h1002,                1'b1, 5);
        tbl[6] = mkVec(1'b1, 2'd2, 64'h1000,                 12'h004, 64'h1004,                1'b0, 6);
        tbl[7] = mkVec(1'b0, 2'd1, 64'h1001,                 12'h000, 64'h1001,                1'b1, 7);

        reset = 1'b1; flush = 1'b0; issValid = 1'b0; memReady = 1'b1;
        setIss(tbl[0]);
        cyc(); cyc();
        check("reset_memValid", 64'(aMemValid), 64'd0);
        check("reset_issReady", 64'(aIssReady), 64'd1);
        check("reset_stallCnt", 64'(aStallCnt), 64'd0);
        #3 reset = 1'b0;
        cyc();

        // Single load, latency
        offer(tbl[0], 4, acc);
        check("single_acc", 64'(acc), 64'd1);
        @(negedge clk);
        check("lat_cyc1_valid", 64'(aMemValid), 64'd0);
        cyc();
        @(negedge clk);
        check("lat_cyc2_valid", 64'(aMemValid), 64'd1);
        check("lat_cyc2_addr", aMemAddr, 64'hFF8);
        cyc();
        waitDrain("single_drain", 10);

        // Back-pressure: three accepted, fourth refused
        memReady = 1'b0;
        offer(randVec(), 1, a1);
        offer(randVec(), 1, a2);
        offer(randVec(), 1, a3);
        offer(randVec(), 3, a4);
        check("bp_acc1", 64'(a1), 64'd1);
        check("bp_acc2", 64'(a2), 64'd1);
        check("bp_acc3", 64'(a3), 64'd1);
        check("bp_acc4_refused", 64'(a4), 64'd0);
        @(negedge clk);
        check("bp_full_ready", 64'(aIssReady), 64'd0);
        check("bp_stall4", 64'(aStallCnt), 64'd4);
        cyc();
        memReady = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(aIssReady), 64'd0);
        check("bp_stall5", 64'(aStallCnt), 64'd5);
        cyc();
        @(negedge clk);
        check("bp_restart_ready", 64'(aIssReady), 64'd1);
        cyc();
        waitDrain("bp_drain", 10);
        check("bp_stall_final", 64'(aStallCnt), 64'd5);

        // Table vectors at full throughput
        for (int i = 0; i < 8; i++) begin
            offer(tbl[i], 1, acc);
            check($sformatf("tbl%0d_acc", i), 64'(acc), 64'd1);
        end
        waitDrain("tbl_drain", 12);

        // Fill, then stream from the full state
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) offer(randVec(), 2, acc);
        memReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(randVec(), 4, acc);
            check($sformatf("stream%0d_acc", i), 64'(acc), 64'd1);
        end
        waitDrain("stream_drain", 12);

        // Asynchronous reset mid-stream
        memReady = 1'b0;
        offer(randVec(), 2, acc);
        offer(randVec(), 2, acc);
        check("pre_reset_valid", 64'(aMemValid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_valid", 64'(aMemValid), 64'd0);
        check("async_reset_stall", 64'(aStallCnt), 64'd0);
        check("async_reset_ready", 64'(aIssReady), 64'd1);
        sbQ.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        cyc();

        // Flush with three ops in flight
        offer(randVec(), 2, acc);
        offer(randVec(), 2, acc);
        offer(randVec(), 2, acc);
        flush = 1'b1; memReady = 1'b1;
        setIss(randVec()); issValid = 1'b1;
        @(negedge clk);
        check("flush_cycle_valid", 64'(aMemValid), 64'd0);
        cyc();
        flush = 1'b0; issValid = 1'b0;
        @(negedge clk);
        check("post_flush_ready", 64'(aIssReady), 64'd1);
        check("post_flush_valid", 64'(aMemValid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge clk);
            check($sformatf("flush_idle%0d_valid", i), 64'(aMemValid), 64'd0);
        end
        check("flush_keeps_stall", 64'(aStallCnt), 64'd1);
        cyc();

        // Issue handshake in a flush cycle is discarded
        flush = 1'b1;
        setIss(randVec()); issValid = 1'b1;
        @(negedge clk);
        check("flush_hs_ready", 64'(aIssReady), 64'd1);
        cyc();
        flush = 1'b0; issValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("discard%0d_valid", i), 64'(aMemValid), 64'd0);
            cyc();
        end

        // 32-bit address wrap on dutB, two AGEN stages
        v = mkVec(1'b0, 2'd2, 64'hFFFF_FFFC, 12'h008, 64'h1_0000_0004, 1'b0, 9);
        setIss(v); issValid = 1'b1;
        @(negedge clk);
        check("wrap_b_ready", 64'(bIssReady), 64'd1);
        if (aIssReady) sbQ.push_back(toExp(v));
        cyc();
        issValid = 1'b0;
        @(negedge clk);
        check("wrap_b_cyc1_valid", 64'(bMemValid), 64'd0);
        cyc();
        @(negedge clk);
        check("wrap_b_cyc2_valid", 64'(bMemValid), 64'd0);
        cyc();
        @(negedge clk);
        check("wrap_b_cyc3_valid", 64'(bMemValid), 64'd1);
        check("wrap_b_addr", 64'(bMemAddr), 64'h4);
        check("wrap_b_misalign", 64'(bMemMisalign), 64'd0);
        cyc();
        waitDrain("wrap_drain", 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
